adder_operand_loader: RTL and testbench

- Upstream stage for the wide pipelined adder benchmark (143-bit operands, 144-bit registered sum).
- Accepts operands as narrow chunks over a valid/ready stream: operand A first, then operand B, least-significant chunk first.
- Assembles both operands in shadow buffers, then updates the two full-width outputs that drive the adder's a/b inputs in a single cycle, with a one-cycle out_valid strobe.
- Keeps the adder's input pins narrow at the I/O boundary while the full-width datapath stays intact.

---
 rtl/adder_operand_loader.sv | 124 ++++++++++++
 tb/tb_adder_operand_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_loader.sv
// Chunked operand loader for the wide pipelined adder: assembles A then B
// from narrow beats and presents both full-width operands in one cycle.
module adder_operand_loader #(
    parameter int ADDER_WIDTH = 143,
    parameter int CHUNK_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CHUNK_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [ADDER_WIDTH-1:0] a_out,
    output logic [ADDER_WIDTH-1:0] b_out,
    output logic                   out_valid,
    output logic [COUNT_WIDTH-1:0] pair_count
);

    localparam int NUM_CHUNKS = (ADDER_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic {
        LOAD_A,
        LOAD_B
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ADDER_WIDTH-1:0] a_buf_q, a_buf_d;
    logic [ADDER_WIDTH-1:0] b_buf_q, b_buf_d;
    logic [ADDER_WIDTH-1:0] a_out_q, a_out_d;
    logic [ADDER_WIDTH-1:0] b_out_q, b_out_d;
    logic                   out_valid_q, out_valid_d;
    logic [COUNT_WIDTH-1:0] pair_count_q, pair_count_d;
    logic [ADDER_WIDTH-1:0] merged;
    logic                   accept;

    assign in_ready = ~reset;
    assign accept   = in_valid & in_ready & ~flush;

    // Bits of the final chunk above ADDER_WIDTH-1 simply have no destination.
    always_comb begin
        merged = (state_q == LOAD_A) ? a_buf_q : b_buf_q;
        for (int i = 0; i < ADDER_WIDTH; i++) begin
            if ((i / CHUNK_WIDTH) == int'(idx_q)) begin
                merged[i] = in_data[i % CHUNK_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_buf_d      = a_buf_q;
        b_buf_d      = b_buf_q;
        a_out_d      = a_out_q;
        b_out_d      = b_out_q;
        out_valid_d  = 1'b0;
        pair_count_d = pair_count_q;
        if (flush) begin
            state_d = LOAD_A;
            idx_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                LOAD_A: begin
                    a_buf_d = merged;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                LOAD_B: begin
                    b_buf_d = merged;
                    if (idx_q == LAST_IDX) begin
                        a_out_d      = a_buf_q;
                        b_out_d      = merged;
                        out_valid_d  = 1'b1;
                        pair_count_d = pair_count_q + COUNT_WIDTH'(1);
                        idx_d        = '0;
                        state_d      = LOAD_A;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD_A;
            idx_q        <= '0;
            a_buf_q      <= '0;
            b_buf_q      <= '0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            out_valid_q  <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_buf_q      <= a_buf_d;
            b_buf_q      <= b_buf_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            out_valid_q  <= out_valid_d;
            pair_count_q <= pair_count_d;
        end
    end

    assign a_out      = a_out_q;
    assign b_out      = b_out_q;
    assign out_valid  = out_valid_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader; a second instance with a
// 4-bit pair counter shares the stimulus to exercise counter wrap.
module tb_adder_operand_loader;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          flush;
    logic [15:0]   in_data;
    logic          rdy, rdy4;
    logic [142:0]  a_out, b_out, a4, b4;
    logic          ov, ov4;
    logic [15:0]   pc;
    logic [3:0]    pc4;

    always #5 clk = ~clk;

    adder_operand_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy), .flush(flush), .a_out(a_out), .b_out(b_out),
        .out_valid(ov), .pair_count(pc)
    );

    adder_operand_loader #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy4), .flush(flush), .a_out(a4), .b_out(b4),
        .out_valid(ov4), .pair_count(pc4)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [142:0] exp_a = '0;
    logic [142:0] exp_b = '0;
    int exp_pairs = 0;
    int exp_pulses = 0;
    int cyc = 0;
    int ov_seen = 0;
    int last_pulse = 0;
    int pulse_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov) begin
            ov_seen    <= ov_seen + 1;
            pulse_gap  <= cyc - last_pulse;
            last_pulse <= cyc;
        end
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
        #2;
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_ov", ov, 0);
        check("rst_pc", pc, 0);
        check("rst_pc4", pc4, 0);
        check("rst_rdy", rdy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rdy_hi", rdy, 1);
        exp_a     = '0;
        exp_b     = '0;
        exp_pairs = 0;
    endtask

    task automatic beat(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [143:0] a, input logic [143:0] b,
                             input int gap_every);
        logic [15:0] d;
        for (int j = 0; j < 18; j++) begin
            d = (j < 9) ? a[j*16 +: 16] : b[(j-9)*16 +: 16];
            beat(d);
            if (j < 17) begin
                check("hold_a", a_out, exp_a);
                check("hold_b", b_out, exp_b);
                check("ov_low", ov, 0);
                if (gap_every > 0 && ((j + 1) % gap_every) == 0) begin
                    in_valid = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    check("gap_ov", ov, 0);
                end
            end else begin
                in_valid = 1'b0;
                exp_a = a[142:0];
                exp_b = b[142:0];
                exp_pairs++;
                exp_pulses += 2;
                check("ov_hi", ov, 1);
                check("a_out", a_out, exp_a);
                check("b_out", b_out, exp_b);
                check("pc", pc, exp_pairs[15:0]);
                check("ov4_hi", ov4, 1);
                check("a4", a4, exp_a);
                check("pc4", pc4, exp_pairs[3:0]);
            end
        end
    endtask

    logic [143:0] va, vb;
    logic [15:0]  c;

    initial begin
        reset = 1'b1;
        #1;
        do_reset();

        // 1: all-ones A (top bit dropped), B = 1
        va = '1;
        vb = 144'd1;
        send_pair(va, vb, 0);
        @(posedge clk);
        #1;
        check("t1_ov_once", ov, 0);

        // 2: same data with gaps
        do_reset();
        send_pair(va, vb, 2);
        @(posedge clk);
        #1;
        check("t2_ov_once", ov, 0);

        // 3: partial A then flush with a beat present
        for (int j = 0; j < 5; j++) beat(16'hAAAA);
        flush = 1'b1;
        in_data = 16'hAAAA;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_ov", ov, 0);
        check("fl_pc", pc, exp_pairs[15:0]);
        check("fl_a", a_out, exp_a);
        va = {9{16'h1234}};
        vb = '0;
        send_pair(va, vb, 0);
        check("t3_pc", pc, 16'd2);

        // 4: async reset in the middle of a B load
        va = {9{16'h0F0F}};
        vb = {9{16'h00FF}};
        send_pair(va, vb, 0);
        for (int j = 0; j < 13; j++) beat(16'h5555);
        #2;
        reset = 1'b1;
        #1;
        check("ar_a", a_out, 0);
        check("ar_b", b_out, 0);
        check("ar_pc", pc, 0);
        check("ar_ov", ov, 0);
        check("ar_rdy", rdy, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_a = '0;
        exp_b = '0;
        exp_pairs = 0;
        va = {9{16'hC3A5}};
        vb = {9{16'h1111}};
        send_pair(va, vb, 0);

        // 5: back-to-back pairs
        va = {9{16'h2468}};
        vb = {9{16'h1357}};
        send_pair(va, vb, 0);
        va = {9{16'h8642}};
        vb = {9{16'h7531}};
        send_pair(va, vb, 0);
        @(negedge clk);
        #1;
        check("b2b_gap", pulse_gap, 18);
        @(posedge clk);
        #1;

        // 6: counter wrap on the 4-bit instance
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            c  = 16'(k) * 16'h0101;
            va = {9{c}};
            vb = {9{~c}};
            send_pair(va, vb, 0);
            if (k == 15) check("wrap15", pc4, 15);
            if (k == 16) check("wrap16", pc4, 0);
            if (k == 17) check("wrap17", pc4, 1);
        end
        check("pc17", pc, 17);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("pulses", ov_seen, exp_pulses / 2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
